// File: rtl/hpm_counter_bank.sv
// Parametrised cycle/instret/event counter bank with mcountinhibit and a registered CSR port.
// Define HPM_OVF_IRQ_EN to add sticky per-counter overflow bits at 0x323 and the ovf_irq output.
module hpm_counter_bank #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               retire_valid,
    input  logic [NUM_EVT-1:0] event_i,
    input  logic               csr_req,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_rvalid,
    output logic               csr_illegal
`ifdef HPM_OVF_IRQ_EN
    ,
    output logic               ovf_irq
`endif
);

    localparam int          NUM_CNT      = 3 + NUM_EVT;
    localparam logic [4:0]  LAST_IDX     = 5'(NUM_CNT - 1);
    localparam logic [11:0] ADDR_INHIBIT = 12'h320;
`ifdef HPM_OVF_IRQ_EN
    localparam logic [11:0] ADDR_OVF     = 12'h323;
`endif

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // Bit 1 belongs to the time CSR, which this bank does not hold, so its bit stays zero.
    function automatic logic [31:0] impl_mask_f();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (i != 1) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [31:0] IMPL_MASK = impl_mask_f();

    function automatic logic [31:0] apply_op(input csr_op_e op, input logic [31:0] old_v,
                                             input logic [31:0] wdata);
        case (op)
            OP_RW:   return wdata;
            OP_RS:   return old_v | wdata;
            OP_RC:   return old_v & ~wdata;
            default: return old_v;
        endcase
    endfunction

    csr_op_e           op;
    logic [CNT_W-1:0]  cnt [NUM_CNT];
    logic [31:0]       inhibit;

    logic [4:0]        sel_idx;
    logic              sel_hi;
    logic              user_sp;
    logic              mach_sp;
    logic              idx_ok;
    logic              is_write;
    logic              req_legal;
    logic [CNT_W-1:0]  cnt_sel;
    logic [31:0]       old_val;
    logic [31:0]       new_val;
    logic [CNT_W-1:0]  cnt_wdata;
    logic [NUM_CNT-1:0] cnt_we;
    logic [NUM_CNT-1:0] inc;
    logic              inh_we;
`ifdef HPM_OVF_IRQ_EN
    logic [31:0]       ovf_bits;
    logic [31:0]       ovf_next;
    logic [31:0]       wrap;
    logic              ovf_we;
`endif

    assign op = csr_op_e'(csr_op);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_idx   = csr_addr[4:0];
        sel_hi    = csr_addr[7];
        user_sp   = (csr_addr[11:8] == 4'hC) && (csr_addr[6:5] == 2'b00);
        mach_sp   = (csr_addr[11:8] == 4'hB) && (csr_addr[6:5] == 2'b00);
        idx_ok    = (sel_idx == 5'd0) || ((sel_idx >= 5'd2) && (sel_idx <= LAST_IDX));
        is_write  = (op == OP_RW) || ((op != OP_READ) && (csr_wdata != '0));
        cnt_sel   = '0;
        old_val   = '0;
        req_legal = 1'b0;
        cnt_we    = '0;
        inh_we    = 1'b0;
`ifdef HPM_OVF_IRQ_EN
        ovf_we    = 1'b0;
`endif

        for (int i = 0; i < NUM_CNT; i++) begin
            if (sel_idx == 5'(i)) cnt_sel = cnt[i];
        end

        // RS/RC with a zero operand is a pure read, which keeps it legal on the user aliases.
        if ((user_sp || mach_sp) && idx_ok) begin
            old_val   = sel_hi ? 32'(cnt_sel[CNT_W-1:32]) : cnt_sel[31:0];
            req_legal = mach_sp || !is_write;
            for (int i = 0; i < NUM_CNT; i++) begin
                if (sel_idx == 5'(i)) cnt_we[i] = csr_req && mach_sp && is_write;
            end
        end else if (csr_addr == ADDR_INHIBIT) begin
            old_val   = inhibit;
            req_legal = 1'b1;
            inh_we    = csr_req && is_write;
        end
`ifdef HPM_OVF_IRQ_EN
        else if (csr_addr == ADDR_OVF) begin
            old_val   = ovf_bits;
            req_legal = 1'b1;
            ovf_we    = csr_req && is_write;
        end
`endif

        new_val   = apply_op(op, old_val, csr_wdata);
        cnt_wdata = sel_hi ? {new_val[CNT_W-33:0], cnt_sel[31:0]}
                           : {cnt_sel[CNT_W-1:32], new_val};
    end

    always_comb begin
        inc    = '0;
        inc[0] = !inhibit[0];
        inc[2] = retire_valid && !inhibit[2];
        for (int k = 0; k < NUM_EVT; k++) begin
            inc[3+k] = event_i[k] && !inhibit[3+k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
        end else begin
            // A CSR write replaces the counter and swallows that cycle's increment.
            for (int i = 0; i < NUM_CNT; i++) begin
                if (cnt_we[i]) cnt[i] <= cnt_wdata;
                else if (inc[i]) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            csr_rvalid  <= 1'b0;
            csr_illegal <= 1'b0;
            csr_rdata   <= '0;
            inhibit     <= '0;
        end else begin
            csr_rvalid  <= csr_req;
            csr_illegal <= csr_req && !req_legal;
            csr_rdata   <= (csr_req && req_legal) ? old_val : '0;
            if (inh_we) inhibit <= new_val & IMPL_MASK;
        end
    end

`ifdef HPM_OVF_IRQ_EN
    // Wrap is ORed after the software update so a same-cycle clear cannot lose an overflow.
    always_comb begin
        wrap = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            wrap[i] = inc[i] && !cnt_we[i] && (&cnt[i]);
        end
        ovf_next = (ovf_we ? (new_val & IMPL_MASK) : ovf_bits) | wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_bits <= '0;
            ovf_irq  <= 1'b0;
        end else begin
            ovf_bits <= ovf_next;
            ovf_irq  <= |ovf_next;
        end
    end
`endif

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Scoreboard bench for hpm_counter_bank: expected responses are queued at issue and matched at rvalid.
// The cycle-counter read after reset has a fixed offset of 0 (first rst=1 edge counts as 1).
module tb_hpm_counter_bank;

    localparam int NUM_EVT = 4;
    localparam int CNT_W   = 64;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] RW = 2'b01;
    localparam logic [1:0] RS = 2'b10;
    localparam logic [1:0] RC = 2'b11;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               retire_valid = 1'b0;
    logic [NUM_EVT-1:0] event_i = '0;
    logic               csr_req = 1'b0;
    logic [11:0]        csr_addr = '0;
    logic [1:0]         csr_op = '0;
    logic [31:0]        csr_wdata = '0;
    logic [31:0]        csr_rdata;
    logic               csr_rvalid;
    logic               csr_illegal;
`ifdef HPM_OVF_IRQ_EN
    logic               ovf_irq;
`endif

    always #5 clk = ~clk;

    hpm_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .retire_valid (retire_valid),
        .event_i      (event_i),
        .csr_req      (csr_req),
        .csr_addr     (csr_addr),
        .csr_op       (csr_op),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_rvalid   (csr_rvalid),
        .csr_illegal  (csr_illegal)
`ifdef HPM_OVF_IRQ_EN
        ,
        .ovf_irq      (ovf_irq)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        ill;
        logic        chk_data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic exp_ill, input logic chk_data);
        exp_t e;
        csr_req   = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wdata;
        e.tag      = tag;
        e.data     = exp_data;
        e.ill      = exp_ill;
        e.chk_data = chk_data;
        e.due      = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        csr_req   = 1'b0;
        csr_op    = RD;
        csr_wdata = '0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_rvalid"}, 64'(csr_rvalid), 64'd1);
            check({e.tag, "_illegal"}, 64'(csr_illegal), 64'(e.ill));
            if (e.chk_data) check(e.tag, 64'(csr_rdata), 64'(e.data));
        end else if (csr_rvalid) begin
            check("unexpected_rvalid", 64'(csr_rvalid), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rvalid", 64'(csr_rvalid), 64'd0);
        check("rst_illegal", 64'(csr_illegal), 64'd0);
        check("rst_rdata", 64'(csr_rdata), 64'd0);
`ifdef HPM_OVF_IRQ_EN
        check("rst_ovf_irq", 64'(ovf_irq), 64'd0);
`endif
        rst = 1'b1;
        idle(10);
        issue("cycle_after_reset", RD, 12'hC00, 32'd0, 32'd10, 1'b0, 1'b1);
        issue("instret_after_reset", RD, 12'hC02, 32'd0, 32'd0, 1'b0, 1'b1);

        // instret inhibit window
        issue("inh_set", RW, 12'h320, 32'h4, 32'h0, 1'b0, 1'b1);
        retire_valid = 1'b1; idle(5); retire_valid = 1'b0;
        issue("inh_clr", RW, 12'h320, 32'h0, 32'h4, 1'b0, 1'b1);
        retire_valid = 1'b1; idle(3); retire_valid = 1'b0;
        issue("instret_3", RD, 12'hC02, 32'd0, 32'd3, 1'b0, 1'b1);

        // the increment on the inhibit-write edge still uses the old inhibit value
        retire_valid = 1'b1;
        issue("inh_set_all", RW, 12'h320, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        idle(2);
        retire_valid = 1'b0;
        issue("inh_mask", RW, 12'h320, 32'h0, 32'h7D, 1'b0, 1'b1);
        issue("instret_edge", RD, 12'hC02, 32'd0, 32'd4, 1'b0, 1'b1);

        // low-half wrap carries into the high half
        issue("b80_wr", RW, 12'hB80, 32'h1, 32'h0, 1'b0, 1'b1);
        issue("b00_wr", RW, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        idle(1);
        issue("c00_wrap", RD, 12'hC00, 32'd0, 32'd0, 1'b0, 1'b1);
        issue("c80_wrap", RD, 12'hC80, 32'd0, 32'd2, 1'b0, 1'b1);

        // event counter write/increment collision and RS/RC
        event_i = 4'b0001;
        issue("b03_wr", RW, 12'hB03, 32'h100, 32'h0, 1'b0, 1'b1);
        event_i = '0;
        issue("c03_write_wins", RD, 12'hC03, 32'd0, 32'h100, 1'b0, 1'b1);
        issue("c03_rw_ill", RW, 12'hC03, 32'h5, 32'h0, 1'b1, 1'b1);
        issue("c03_rs0", RS, 12'hC03, 32'h0, 32'h100, 1'b0, 1'b1);
        event_i = 4'b0001; idle(1); event_i = '0;
        issue("b03_rs", RS, 12'hB03, 32'h3, 32'h101, 1'b0, 1'b1);
        issue("b03_rc", RC, 12'hB03, 32'h100, 32'h103, 1'b0, 1'b1);
        issue("b83_rw", RW, 12'hB83, 32'hABCD, 32'h0, 1'b0, 1'b1);
        issue("c83_hi", RD, 12'hC83, 32'd0, 32'hABCD, 1'b0, 1'b1);
        issue("c03_lo", RD, 12'hC03, 32'd0, 32'h3, 1'b0, 1'b1);
        issue("c03_rs_ill", RS, 12'hC03, 32'h1, 32'h0, 1'b1, 1'b1);

        // address decode boundaries
        issue("unmapped", RD, 12'h7FF, 32'd0, 32'h0, 1'b1, 1'b1);
        issue("idx1", RD, 12'hC01, 32'd0, 32'h0, 1'b1, 1'b1);
        issue("idx_oob", RD, 12'hC07, 32'd0, 32'h0, 1'b1, 1'b1);
        issue("b07_oob", RW, 12'hB07, 32'h1, 32'h0, 1'b1, 1'b1);
        issue("c06_last", RD, 12'hC06, 32'd0, 32'h0, 1'b0, 1'b1);

`ifdef HPM_OVF_IRQ_EN
        issue("ovf_pre_hi", RW, 12'hB83, 32'hFFFF_FFFF, 32'hABCD, 1'b0, 1'b1);
        issue("ovf_pre_lo", RW, 12'hB03, 32'hFFFF_FFFF, 32'h3, 1'b0, 1'b1);
        check("ovf_irq_idle", 64'(ovf_irq), 64'd0);
        event_i = 4'b0001; idle(1); event_i = '0;
        check("ovf_irq_set", 64'(ovf_irq), 64'd1);
        issue("ovf_rd", RD, 12'h323, 32'd0, 32'h8, 1'b0, 1'b1);
        issue("ovf_rc", RC, 12'h323, 32'h8, 32'h8, 1'b0, 1'b1);
        check("ovf_irq_clr", 64'(ovf_irq), 64'd0);
        issue("ovf_c03", RD, 12'hC03, 32'd0, 32'h0, 1'b0, 1'b1);
`else
        issue("ovf_absent", RD, 12'h323, 32'd0, 32'h0, 1'b1, 1'b1);
`endif

        // reset on the same edge as a request drops it
        csr_req  = 1'b1;
        csr_op   = RD;
        csr_addr = 12'hC00;
        rst      = 1'b0;
        @(negedge clk);
        csr_req  = 1'b0;
        rst      = 1'b1;
        check("rst_drop_rvalid", 64'(csr_rvalid), 64'd0);
        check("rst_drop_rdata", 64'(csr_rdata), 64'd0);
        issue("post_rst_cycle", RD, 12'hC00, 32'd0, 32'h0, 1'b0, 1'b1);
        issue("post_rst_instret", RD, 12'hC02, 32'd0, 32'h0, 1'b0, 1'b1);
        issue("post_rst_evt", RD, 12'hC03, 32'd0, 32'h0, 1'b0, 1'b1);
        issue("post_rst_evt_hi", RD, 12'hC83, 32'd0, 32'h0, 1'b0, 1'b1);
        issue("post_rst_cyc_hi", RD, 12'hC80, 32'd0, 32'h0, 1'b0, 1'b1);
        issue("post_rst_inh", RD, 12'h320, 32'd0, 32'h0, 1'b0, 1'b1);
        idle(2);
        check("drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised CSR counter bank for the RV32 pipeline. It generalises the fixed cycle/instret counters to configurable counter width plus NUM_EVT event counters (hpmcounter3+). It adds machine-mode writable shadows, a count-inhibit register, and a registered CSR read port. It sits beside the EXE stage: CSR instructions issue requests here, and the WB side supplies flush-qualified retire and event pulses.

## Interface
- NUM_EVT, default 4: number of event counters, legal 1..29; counter k maps to index 3+k.
- CNT_W, default 64: counter width, legal 33..64. High-half reads zero-extend bits CNT_W-1:32.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- retire_valid  in  1  one instruction retired this cycle, already qualified against flushes.
- event_i  in  NUM_EVT  per-counter increment pulse, bit k feeds counter 3+k.
- csr_req  in  1  CSR access this cycle.
- csr_addr  in  12  CSR address.
- csr_op  in  2  00 read, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- csr_wdata  in  32  write operand.
- csr_rdata  out  32  read data, registered.
- csr_rvalid  out  1  csr_rdata valid, one-cycle pulse.
- csr_illegal  out  1  access rejected, pulse aligned with csr_rvalid.
- ovf_irq  out  1  sticky overflow interrupt; exists only with HPM_OVF_IRQ_EN.

## Operation
- Counters: cycle (index 0), instret (index 2), event 3..3+NUM_EVT-1; each CNT_W bits.
- Address map:
  - user read-only: 0xC00/0xC02/0xC03+k (low 32 bits), 0xC80/0xC82/0xC83+k (high bits).
  - machine read/write: 0xB00/0xB02/0xB03+k (low), 0xB80/0xB82/0xB83+k (high).
  - mcountinhibit: 0x320. Bit 0 cycle, bit 2 instret, bit 3+k event k. Bit 1 and unimplemented bits read 0 and ignore writes.
- Increment rules, per cycle, when the counter's inhibit bit is 0:
  - cycle +1 every cycle.
  - instret +1 when retire_valid.
  - event k +1 when event_i[k].
- Counters wrap from 2^CNT_W-1 to 0 with no stall.
- csr_rdata returns the counter value sampled before the request edge; for RW/RS/RC that is the pre-write value.
- Writes:
  - RW writes csr_wdata.
  - RS writes old | wdata.
  - RC writes old & ~wdata.
  - Writing a low half keeps the high bits; writing a high half keeps the low 32.
  - High-half writes take csr_wdata[CNT_W-33:0].
- A write and an increment to the same counter in the same cycle: the write wins, and that cycle's increment is dropped.
- Illegal (csr_illegal=1, csr_rdata=0, no state change):
  - unmapped address;
  - non-read op (csr_op≠00) to any 0xC.. address;
  - counter index beyond 2+NUM_EVT.
- An RS/RC with wdata=0 is a read, not a write, and is legal on 0xC.. addresses.

## Timing
- Reset (rst=0 at an edge): all counters 0, mcountinhibit 0, csr_rdata 0, csr_rvalid 0, csr_illegal 0, ovf_irq 0.
- Reset in the middle of a request drops the request: no rvalid follows.
- Read latency: request sampled at edge N, then csr_rdata/csr_rvalid valid during cycle N+1. Back-to-back requests yield one response per cycle.
- Write visibility: a write at edge N is seen by a request sampled at edge N+1.
- Writing mcountinhibit at edge N affects increments from edge N+1 on. The increment at edge N still follows the old inhibit value.
- No backpressure: csr_req is always accepted.

## Configuration
- HPM_OVF_IRQ_EN, when defined:
  - each counter has a sticky overflow bit, set on wrap from all-ones to 0;
  - ovf_irq is the registered OR of the overflow bits, asserted the cycle after the wrap edge;
  - bits are readable at 0x323 (same bit layout as mcountinhibit);
  - writing 1 to a bit at 0x323 via RC clears it;
  - a wrap and a clear in the same cycle leave the bit set.
- When undefined: no overflow logic, no ovf_irq port, 0x323 is illegal.

## Test plan
- Reset, then 10 idle cycles, then read 0xC00 → csr_rdata=10 (±fixed offset documented in the bench) one cycle later; read 0xC02 → 0.
- Set mcountinhibit to 0x4, pulse retire_valid 5 cycles, clear the inhibit, pulse retire_valid 3 cycles, read 0xC02 → 3.
- RW 0xB80=0x1 then RW 0xB00=0xFFFFFFFF, wait 1 cycle, read 0xC80 → 2 and 0xC00 → 0 (low wrap carries to the high half).
- Write 0xB03 at the same edge as event_i[0]=1 with wdata=0x100 → read gives 0x100, not 0x101. RW to 0xC03 → csr_illegal=1 and the counter is unchanged.
- With HPM_OVF_IRQ_EN and CNT_W=33: preload event counter 0 to 2^33-1, pulse event_i[0] → ovf_irq=1 the next cycle. RC 0x323 with 0x8 → ovf_irq=0.
- Assert rst=0 for 1 cycle while a read request is in flight → csr_rvalid stays 0, and all counters read 0 afterward.
